char_blitter: RTL and testbench
===============================

Name: char_blitter

Overview:
- Upstream writer for the framebuffer VRAM write port.
- Accepts one character-draw command at a time: code, cell column/row, foreground and background colour.
- Fetches the 8 glyph rows from the character ROM and writes the 8x8 cell into VRAM as 24-bit RGB pixels, one pixel per clock.
- The VGA scanout stage reads the result through the VRAM read port.

Parameters:
- FB_W, 320, framebuffer width in pixels (VRAM linear address = y*FB_W + x)
- CELL_COLS, 40, character cells per line
- CELL_ROWS, 25, character cell lines
- DW, 24, pixel width {R[23:16],G[15:8],B[7:0]}
- AW, 16, VRAM address width
- CAW, 11, character ROM address width ({code[7:0],glyph_row[2:0]})

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge
- RESET_N  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  high only in IDLE; command accepted on req_valid&&req_ready
- req_char  in  8  character code
- req_col  in  6  cell column 0..CELL_COLS-1
- req_row  in  5  cell row 0..CELL_ROWS-1
- req_fg  in  DW  foreground colour
- req_bg  in  DW  background colour
- crom_adr  out  CAW  character ROM address
- crom_q  in  8  glyph row; bit 7 = leftmost pixel; valid the cycle after crom_adr is presented
- vram_wclk  out  1  VRAM write clock, continuous assign of CLOCK_50
- vram_wadr  out  AW  VRAM write address
- vram_d  out  DW  VRAM write data
- vram_we  out  1  VRAM write enable
- busy  out  1  high from accept until return to IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  one-cycle pulse, coincident with done, when the command was out of range

Behaviour:
- Reset (async, RESET_N low): state IDLE, req_ready=1, busy=0, done=0, err=0, vram_we=0, vram_wadr=0, vram_d=0, crom_adr=0, all internal counters 0.
- Command registers: code, fg, bg, row base address.
  - Base = req_row*(8*FB_W) + req_col*8, computed in AW bits at accept. Max for defaults: 63999, so no overflow.
- States:
  - IDLE: on accept, go to CHECK. If req_valid is held after done, the next command is accepted on the first IDLE cycle (no bubble beyond IDLE).
  - CHECK: if col>=CELL_COLS or row>=CELL_ROWS, go to DONE with err set and perform no VRAM writes. Otherwise set gr=0 and go to FETCH.
  - FETCH: drive crom_adr={code,gr}, then go to LATCH.
  - LATCH: capture crom_q into an 8-bit shift register, set px=0, then go to DRAW.
  - DRAW: one cycle per pixel, 8 cycles.
    - vram_we=1, vram_wadr=base+gr*FB_W+px, vram_d=shift[7]?fg:bg; shift left by 1.
    - After px=7: if gr=7 go to DONE, else gr++ and go to FETCH.
  - DONE: done=1 (err per CHECK), then go to IDLE.
- Outputs are registered; vram_we is low in every state except DRAW.
- Latency, valid command: accept → 1 (CHECK) + 8×(1+1+8) + 1 (DONE) = 82 cycles; exactly 64 write strobes.
- Latency, invalid command: accept → done/err 2 cycles later; 0 writes.
- Inputs are sampled only at accept; changes to req_* while busy are ignored.
- Reset mid-draw aborts immediately: vram_we drops asynchronously and no done pulse is issued. A partially drawn cell is left as-is.
- vram_wadr/vram_d hold their last value when vram_we=0.

Optional Feature:
- TRANSPARENT_BG_EN
  - Defined: for glyph bits of 0, vram_we=0 in that DRAW cycle. Only foreground pixels are written (overlay); cycle timing is unchanged (82 cycles), and write count equals the popcount of the glyph.
  - Undefined: every pixel is written, with bg for 0 bits.

Decomposition:
- Package vdp_pkg:
  - typedef pixel_t (logic[DW-1:0]) and localparams FB_W, CELL_COLS, CELL_ROWS, GLYPH_W=8, GLYPH_H=8.
  - State enum blit_state_t {IDLE, CHECK, FETCH, LATCH, DRAW, DONE}.
- One natural sub-module, blit_addr_gen: computes base and per-pixel address from row/col/gr/px (pure shift-add arithmetic, no multiplier).

Test Plan:
- Reset then idle, with req_valid=0 → req_ready=1, busy=0, vram_we=0 for 100 cycles.
- Char 0x41, col=0, row=0, fg=24'hFFFFFF, bg=24'h000000, ROM model row0=8'b00011000 → first row writes addresses 0..7 with data bg,bg,bg,fg,fg,bg,bg,bg. Glyph row 1 starts at address 320. 64 writes total; done 82 cycles after accept.
- col=39, row=24 → first write address 61752, last write address 63999; no write outside the range 61752..63999.
- col=40, row=0 → done and err pulse 2 cycles after accept, zero writes; req_ready=1 on the following cycle.
- Back-to-back: req_valid held high with two commands → second accepted on the IDLE cycle after done; req_ready=0 throughout the first command.
- Assert RESET_N low at write 30 → vram_we=0 immediately, no done pulse. After release, a new command completes normally. With TRANSPARENT_BG_EN defined, glyph 8'hAA on all rows → 32 writes, all fg, at even px positions.

Source files
------------

// File: rtl/vdp_pkg.sv
// ---------------------------------------------------------------------------
// vdp_pkg
//   Shared types and geometry for the video display pipeline: framebuffer
//   size, character-cell grid, pixel format and the blitter state encoding.
//   Also provides a constant-multiply helper that expands into shift-add
//   logic, so address arithmetic never infers a hardware multiplier.
// ---------------------------------------------------------------------------
package vdp_pkg;

  localparam int FB_W      = 320;  // framebuffer width in pixels
  localparam int CELL_COLS = 40;   // character cells per line
  localparam int CELL_ROWS = 25;   // character cell lines
  localparam int DW        = 24;   // pixel width {R,G,B}
  localparam int AW        = 16;   // VRAM address width
  localparam int CAW       = 11;   // character ROM address width
  localparam int GLYPH_W   = 8;
  localparam int GLYPH_H   = 8;

  typedef logic [DW-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    LATCH,
    DRAW,
    DONE
  } blit_state_t;

  // x * k for a constant k, built from one shifted copy of x per set bit
  // of k. Result is truncated to AW bits.
  function automatic logic [AW-1:0] mul_const(input logic [AW-1:0] x,
                                              input int unsigned k);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < AW; i++) begin
      if (k[i]) acc = acc + (x << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// ---------------------------------------------------------------------------
// blit_addr_gen
//   Purely combinational VRAM address arithmetic for the character blitter.
//   Ports:
//     row_i, col_i  cell row/column of the incoming command
//     base_o        linear address of the cell's top-left pixel
//                   (row*GLYPH_H*FB_W + col*GLYPH_W)
//     base_i        registered cell base address
//     gr_i, px_i    glyph row and pixel within the cell
//     pix_adr_o     base_i + gr_i*FB_W + px_i
// ---------------------------------------------------------------------------
module blit_addr_gen
  import vdp_pkg::*;
(
  input  logic [4:0]    row_i,
  input  logic [5:0]    col_i,
  input  logic [AW-1:0] base_i,
  input  logic [2:0]    gr_i,
  input  logic [2:0]    px_i,
  output logic [AW-1:0] base_o,
  output logic [AW-1:0] pix_adr_o
);

  always_comb begin
    base_o    = mul_const(AW'(row_i), GLYPH_H * FB_W)
              + mul_const(AW'(col_i), GLYPH_W);
    pix_adr_o = base_i + mul_const(AW'(gr_i), FB_W) + AW'(px_i);
  end

endmodule

// File: rtl/char_blitter.sv
// ---------------------------------------------------------------------------
// char_blitter
//   Draws one 8x8 character cell per command into the framebuffer VRAM.
//   For each of the 8 glyph rows it reads the character ROM, then writes the
//   8 pixels of that row one per clock (fg for set bits, bg for clear bits).
//
//   Ports:
//     CLOCK_50, RESET_N        clock, asynchronous active-low reset
//     req_valid/req_ready      command handshake (ready only while idle)
//     req_char/col/row/fg/bg   command fields, sampled at accept only
//     crom_adr, crom_q         character ROM port ({code,glyph_row}), q valid
//                              the cycle after the address is presented
//     vram_wclk/wadr/d/we      VRAM write port
//     busy                     high from accept until back in IDLE
//     done                     one-cycle completion pulse
//     err                      pulses with done when col/row was out of range
//
//   Build option TRANSPARENT_BG_EN: when defined, clear glyph bits suppress
//   the write strobe so only foreground pixels land in VRAM (overlay mode).
//   Cycle timing is identical in both builds.
// ---------------------------------------------------------------------------
module char_blitter
  import vdp_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           RESET_N,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [7:0]     req_char,
  input  logic [5:0]     req_col,
  input  logic [4:0]     req_row,
  input  pixel_t         req_fg,
  input  pixel_t         req_bg,
  output logic [CAW-1:0] crom_adr,
  input  logic [7:0]     crom_q,
  output logic           vram_wclk,
  output logic [AW-1:0]  vram_wadr,
  output pixel_t         vram_d,
  output logic           vram_we,
  output logic           busy,
  output logic           done,
  output logic           err
);

  blit_state_t    state_q;
  logic [2:0]     gr_q;
  logic [2:0]     px_q;
  logic [7:0]     shift_q;
  logic [CAW-1:0] crom_adr_q;
  logic           vram_we_q;
  logic [AW-1:0]  vram_wadr_q;
  pixel_t         vram_d_q;
  logic           req_ready_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  // Command registers: data only, loaded at accept, no reset needed.
  logic [7:0]     code_q;
  pixel_t         fg_q;
  pixel_t         bg_q;
  logic [AW-1:0]  base_q;
  logic           oor_q;

  logic           accept;
  logic [2:0]     gr_d;
  logic [2:0]     px_d;
  logic [2:0]     px_sel;
  logic           draw_bit;
  logic           we_d;
  pixel_t         pix_d;
  logic [AW-1:0]  base_d;
  logic [AW-1:0]  pix_adr;

  assign vram_wclk = CLOCK_50;
  assign accept    = req_valid && req_ready_q;

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign crom_adr  = crom_adr_q;
  assign vram_we   = vram_we_q;
  assign vram_wadr = vram_wadr_q;
  assign vram_d    = vram_d_q;

  blit_addr_gen u_addr (
    .row_i     (req_row),
    .col_i     (req_col),
    .base_i    (base_q),
    .gr_i      (gr_q),
    .px_i      (px_sel),
    .base_o    (base_d),
    .pix_adr_o (pix_adr)
  );

  // The outputs are registered, so on each edge we prepare the pixel that
  // will be on the bus during the *next* cycle: pixel 0 of a row is set up
  // from crom_q while in LATCH, later pixels from the shift register.
  always_comb begin
    gr_d     = gr_q + 3'd1;
    px_d     = px_q + 3'd1;
    px_sel   = (state_q == DRAW) ? px_d : 3'd0;
    draw_bit = (state_q == LATCH) ? crom_q[7] : shift_q[7];
    pix_d    = draw_bit ? fg_q : bg_q;
`ifdef TRANSPARENT_BG_EN
    we_d     = draw_bit;
`else
    we_d     = 1'b1;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (accept) begin
      code_q <= req_char;
      fg_q   <= req_fg;
      bg_q   <= req_bg;
      base_q <= base_d;
      oor_q  <= (req_col >= 6'(CELL_COLS)) || (req_row >= 5'(CELL_ROWS));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      gr_q        <= '0;
      px_q        <= '0;
      shift_q     <= '0;
      crom_adr_q  <= '0;
      vram_we_q   <= 1'b0;
      vram_wadr_q <= '0;
      vram_d_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= CHECK;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        CHECK: begin
          if (oor_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            gr_q       <= 3'd0;
            crom_adr_q <= {code_q, 3'd0};
            state_q    <= FETCH;
          end
        end

        // ROM address is already on the port; wait for the read data.
        FETCH: state_q <= LATCH;

        LATCH: begin
          shift_q   <= {crom_q[6:0], 1'b0};
          px_q      <= 3'd0;
          vram_we_q <= we_d;
          if (we_d) begin
            vram_wadr_q <= pix_adr;
            vram_d_q    <= pix_d;
          end
          state_q <= DRAW;
        end

        DRAW: begin
          if (px_q == 3'd7) begin
            vram_we_q <= 1'b0;
            if (gr_q == 3'd7) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              gr_q       <= gr_d;
              crom_adr_q <= {code_q, gr_d};
              state_q    <= FETCH;
            end
          end else begin
            px_q      <= px_d;
            shift_q   <= {shift_q[6:0], 1'b0};
            vram_we_q <= we_d;
            if (we_d) begin
              vram_wadr_q <= pix_adr;
              vram_d_q    <= pix_d;
            end
          end
        end

        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          vram_we_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_blitter.sv
// ---------------------------------------------------------------------------
// tb_char_blitter
//   Self-checking bench for char_blitter. A character ROM is modelled as a
//   registered array; the expected VRAM write stream of every command is
//   derived from the cell geometry and glyph bits, and compared with the
//   captured write strobes. Build with +define+TRANSPARENT_BG_EN to exercise
//   the overlay variant.
// ---------------------------------------------------------------------------
module tb_char_blitter;
  import vdp_pkg::*;

`ifdef TRANSPARENT_BG_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_char = '0;
  logic [5:0]  req_col  = '0;
  logic [4:0]  req_row  = '0;
  pixel_t      req_fg   = '0;
  pixel_t      req_bg   = '0;
  logic [10:0] crom_adr;
  logic [7:0]  crom_q = '0;
  logic        vram_wclk;
  logic [15:0] vram_wadr;
  pixel_t      vram_d;
  logic        vram_we;
  logic        busy;
  logic        done;
  logic        err;

  char_blitter dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_char (req_char),
    .req_col  (req_col),
    .req_row  (req_row),
    .req_fg   (req_fg),
    .req_bg   (req_bg),
    .crom_adr (crom_adr),
    .crom_q   (crom_q),
    .vram_wclk(vram_wclk),
    .vram_wadr(vram_wadr),
    .vram_d   (vram_d),
    .vram_we  (vram_we),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [7:0] rom [0:2047];
  always @(posedge CLOCK_50) crom_q <= rom[crom_adr];

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [39:0] wq[$];   // observed {addr, data}
  logic [39:0] eq[$];   // expected {addr, data}
  int acc_q[$];
  int done_q[$];
  int done_cnt = 0;
  logic last_err = 1'b0;
  int bad_err = 0;
  int bad_rdy = 0;
  bit rdy_log [0:65535];

  always @(negedge CLOCK_50) begin
    if (vram_we === 1'b1) wq.push_back({vram_wadr, vram_d});
    if (done === 1'b1) begin
      done_cnt++;
      done_q.push_back(cyc);
      last_err = err;
    end
    if (err === 1'b1 && done !== 1'b1) bad_err++;
    if (req_ready === busy) bad_rdy++;
    if (req_valid && req_ready) acc_q.push_back(cyc);
    if (cyc < 65536) rdy_log[cyc] = req_ready;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wa(input int i);
    if (wq.size() > i) return 64'(wq[i][39:24]);
    return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  function automatic logic [63:0] wd(input int i);
    if (wq.size() > i) return 64'(wq[i][23:0]);
    return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  // Expected write stream of one command, straight from cell geometry.
  task automatic model_cmd(input logic [7:0] code, input int col, input int row,
                           input pixel_t fg, input pixel_t bg);
    logic [7:0] g;
    int adr;
    if (col >= CELL_COLS || row >= CELL_ROWS) return;
    for (int gr = 0; gr < 8; gr++) begin
      g = rom[{code, 3'(gr)}];
      for (int px = 0; px < 8; px++) begin
        adr = row * 8 * FB_W + col * 8 + gr * FB_W + px;
        if (g[7-px]) eq.push_back({16'(adr), fg});
        else if (!TRANSP) eq.push_back({16'(adr), bg});
      end
    end
  endtask

  task automatic send(input logic [7:0] code, input logic [5:0] col, input logic [4:0] row,
                      input pixel_t fg, input pixel_t bg, output int acc);
    int n = 0;
    req_char = code; req_col = col; req_row = row; req_fg = fg; req_bg = bg;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("accept_wait_expired", 64'(n >= 300), 64'd0);
    acc = cyc;
    tick();
    req_valid = 1'b0;
    // Scramble the request fields; the command in flight must not see them.
    req_char = 8'($urandom); req_col = 6'($urandom); req_row = 5'($urandom);
    req_fg = 24'($urandom); req_bg = 24'($urandom);
  endtask

  task automatic wait_done(input int prev, input string tag);
    int n = 0;
    while (done_cnt == prev && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_done_expired"}, 64'(done_cnt == prev), 64'd0);
  endtask

  task automatic cmp_writes(input string tag);
    int mism = 0;
    chk({tag, "_nwrites"}, 64'(wq.size()), 64'(eq.size()));
    for (int i = 0; i < wq.size() && i < eq.size(); i++)
      if (wq[i] !== eq[i]) mism++;
    chk({tag, "_wdata"}, 64'(mism), 64'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] code, input logic [5:0] col,
                         input logic [4:0] row, input pixel_t fg, input pixel_t bg);
    int acc, prev;
    bit oor;
    oor = (int'(col) >= CELL_COLS) || (int'(row) >= CELL_ROWS);
    wq.delete(); eq.delete();
    model_cmd(code, int'(col), int'(row), fg, bg);
    prev = done_cnt;
    send(code, col, row, fg, bg, acc);
    wait_done(prev, tag);
    chk({tag, "_latency"}, 64'(done_q[$] - acc), oor ? 64'd2 : 64'd82);
    chk({tag, "_err"}, 64'(last_err), 64'(oor));
    cmp_writes(tag);
  endtask

  initial begin
    int bad, a1, a2, d1, d2, na, n, prev, rsum, odd, nonfg;
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    rom[{8'h41, 3'd0}] = 8'b0001_1000;
    rom[{8'h7E, 3'd0}] = 8'h81;
    rom[{8'h7E, 3'd7}] = 8'h81;
    for (int i = 0; i < 8; i++) rom[{8'hAA, 3'(i)}] = 8'hAA;

    // Reset state
    RESET_N = 1'b0;
    tick(3);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_vram_we", 64'(vram_we), 64'd0);
    chk("rst_vram_wadr", 64'(vram_wadr), 64'd0);
    chk("rst_vram_d", 64'(vram_d), 64'd0);
    chk("rst_crom_adr", 64'(crom_adr), 64'd0);
    chk("wclk_follows_clk", 64'(vram_wclk), 64'(CLOCK_50));
    RESET_N = 1'b1;

    // Idle with no request
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_ready !== 1'b1 || busy !== 1'b0 || vram_we !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_100_cycles", 64'(bad), 64'd0);

    // Character 0x41 at the origin
    run_cmd("A", 8'h41, 6'd0, 5'd0, 24'hFFFFFF, 24'h000000);
`ifndef TRANSPARENT_BG_EN
    for (int px = 0; px < 8; px++) begin
      chk($sformatf("A_row0_adr%0d", px), wa(px), 64'(px));
      chk($sformatf("A_row0_dat%0d", px), wd(px), (px == 3 || px == 4) ? 64'hFFFFFF : 64'h0);
    end
    chk("A_row1_start", wa(8), 64'd320);
`else
    chk("A_overlay_first_adr", wa(0), 64'd3);
    chk("A_overlay_second_adr", wa(1), 64'd4);
`endif

    // Bottom-right cell
    run_cmd("B", 8'h7E, 6'd39, 5'd24, 24'($urandom), 24'($urandom));
    chk("B_first_adr", wa(0), 64'd61752);
    chk("B_last_adr", wq.size() > 0 ? 64'(wq[$][39:24]) : 64'hxxxx_xxxx_xxxx_xxxx, 64'd63999);
    bad = 0;
    foreach (wq[i]) if (wq[i][39:24] < 16'd61752 || wq[i][39:24] > 16'd63999) bad++;
    chk("B_out_of_range_writes", 64'(bad), 64'd0);

    // Out-of-range commands
    run_cmd("C_col40", 8'h20, 6'd40, 5'd0, 24'h123456, 24'h654321);
    tick();
    chk("C_ready_after_done", 64'(req_ready), 64'd1);
    run_cmd("C_row25", 8'h20, 6'd0, 5'd25, 24'h123456, 24'h654321);
    run_cmd("C_max", 8'h33, 6'd63, 5'd31, 24'h0, 24'h1);

    // Random commands, some out of range
    for (int k = 0; k < 6; k++) begin
      run_cmd($sformatf("R%0d", k), 8'($urandom), 6'($urandom_range(0, 45)),
              5'($urandom_range(0, 27)), 24'($urandom), 24'($urandom));
    end

    // Back-to-back with req_valid held
    wq.delete(); eq.delete();
    model_cmd(8'h41, 3, 4, 24'hAA0000, 24'h0000BB);
    model_cmd(8'h99, 10, 12, 24'h00CC00, 24'h112233);
    prev = done_cnt;
    na = acc_q.size();
    req_char = 8'h41; req_col = 6'd3; req_row = 5'd4; req_fg = 24'hAA0000; req_bg = 24'h0000BB;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin tick(); n++; end
    tick();
    req_char = 8'h99; req_col = 6'd10; req_row = 5'd12; req_fg = 24'h00CC00; req_bg = 24'h112233;
    n = 0;
    while (acc_q.size() < na + 2 && n < 300) begin tick(); n++; end
    chk("E_second_accept_expired", 64'(n >= 300), 64'd0);
    tick();
    req_valid = 1'b0;
    wait_done(prev + 1, "E");
    chk("E_done_count", 64'(done_cnt - prev), 64'd2);
    if (acc_q.size() >= na + 2 && done_q.size() >= 2) begin
      a1 = acc_q[na]; a2 = acc_q[na + 1];
      d1 = done_q[done_q.size() - 2]; d2 = done_q[$];
    end else begin
      a1 = 0; a2 = 0; d1 = 0; d2 = 0;
    end
    chk("E_lat1", 64'(d1 - a1), 64'd82);
    chk("E_lat2", 64'(d2 - a2), 64'd82);
    chk("E_no_bubble", 64'(a2), 64'(d1 + 1));
    rsum = 0;
    for (int c = a1 + 1; c <= d1 && c < 65536; c++) rsum += int'(rdy_log[c]);
    chk("E_ready_low_while_busy", 64'(rsum), 64'd0);
    cmp_writes("E");

    // Reset in the middle of drawing
    wq.delete(); eq.delete();
    send(8'h41, 6'd20, 5'd10, 24'hFFFFFF, 24'h000000, a1);
    n = 0;
    while (wq.size() < 30 && n < 200) begin tick(); n++; end
    chk("F_reach_write30_expired", 64'(n >= 200), 64'd0);
    prev = done_cnt;
    RESET_N = 1'b0;
    #1;
    chk("F_we_drops_in_reset", 64'(vram_we), 64'd0);
    chk("F_busy_drops_in_reset", 64'(busy), 64'd0);
    tick(3);
    chk("F_writes_stop", 64'(wq.size()), 64'd30);
    chk("F_no_done_pulse", 64'(done_cnt - prev), 64'd0);
    RESET_N = 1'b1;
    tick();
    run_cmd("F_after", 8'h5C, 6'd7, 5'd2, 24'h0F0F0F, 24'hF0F0F0);

`ifdef TRANSPARENT_BG_EN
    // Overlay: glyph 0xAA on every row
    run_cmd("G", 8'hAA, 6'd5, 5'd3, 24'hABCDEF, 24'h010203);
    chk("G_write_count", 64'(wq.size()), 64'd32);
    odd = 0; nonfg = 0;
    foreach (wq[i]) begin
      if (wq[i][23:0] !== 24'hABCDEF) nonfg++;
      if (((int'(wq[i][39:24]) - (3 * 8 * FB_W + 5 * 8)) % FB_W) % 2 != 0) odd++;
    end
    chk("G_all_fg", 64'(nonfg), 64'd0);
    chk("G_even_px_only", 64'(odd), 64'd0);
`else
    odd = 0; nonfg = 0;
`endif

    chk("err_only_with_done", 64'(bad_err), 64'd0);
    chk("ready_is_not_busy", 64'(bad_rdy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
